// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: receiver state encodings and
// frame-format constants.
package uart_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  localparam int   DATA_BITS  = 8;
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with registered empty/full flags.
// The extra pointer MSB separates the full and empty cases after wrap-around.
module sync_fifo #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          empty,
  output logic          full
);

  logic [DW-1:0] mem [2**AW];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic [AW:0]   wr_ptr_nxt, rd_ptr_nxt;
  logic          do_rd, do_wr;

  // A read while empty is ignored, so a same-cycle write to an empty FIFO is
  // never bypassed. A read while full frees the slot the write lands in.
  assign do_rd      = rd_en && !empty;
  assign do_wr      = wr_en && (!full || do_rd);
  assign wr_ptr_nxt = wr_ptr + (AW+1)'(do_wr);
  assign rd_ptr_nxt = rd_ptr + (AW+1)'(do_rd);

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge values of its inputs regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      empty  <= (wr_ptr_nxt == rd_ptr_nxt);
      full   <= (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]) &&
                (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]);
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and empty flag
  // already mask stale contents, and a reset would block RAM inference.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a FWFT byte FIFO. The bit-period counter is
// re-aligned on every start-bit falling edge seen on the synchronised line.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = 868,
  parameter int FIFO_AW  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       empty,
  output logic       full,
  output logic       frame_err,
  output logic       overflow
);

  localparam int            CW       = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] CNT_HALF = CW'(BAUD_DIV/2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_DIV - 1);
  localparam logic [2:0]    IDX_LAST = 3'(DATA_BITS - 1);

  logic                 rx_meta, rx_s;
  logic [1:0]           state;
  logic [CW-1:0]        cnt;
  logic [2:0]           idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 stop_sample, good_byte, wr_en;

  assign stop_sample = (state == ST_STOP) && (cnt == CNT_LAST);
  assign good_byte   = stop_sample && rx_s;
  // When full, rd_en alone implies a real pop, so it frees the slot.
  assign wr_en       = good_byte && (!full || rd_en);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= IDLE_LEVEL;
      rx_s    <= IDLE_LEVEL;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (rx_s != IDLE_LEVEL) state <= ST_START;
        end
        ST_START: begin
          if (cnt == CNT_HALF) begin
            cnt <= '0;
            idx <= '0;
            // A line already back high at mid-start-bit is treated as noise.
            state <= (rx_s == IDLE_LEVEL) ? ST_IDLE : ST_DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_DATA: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            shreg <= {rx_s, shreg[DATA_BITS-1:1]};
            if (idx == IDX_LAST) state <= ST_STOP;
            else                 idx   <= idx + 3'd1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      frame_err <= stop_sample && !rx_s;
      overflow  <= good_byte && full && !rd_en;
    end
  end

  sync_fifo #(
    .DW(DATA_BITS),
    .AW(FIFO_AW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_data (shreg),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .empty   (empty),
    .full    (full)
  );

endmodule
